// File: rtl/addsub_seq.sv
// addsub_seq: digit-serial adder/subtractor.
// Operands are latched on start. One DIGIT-wide slice is then added per clock,
// least significant digit first, with the carry rippling between cycles.
// The flags and result are published together when the last digit completes.
module addsub_seq #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             control,
  input  logic             carry_in,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, b_reg, res_reg;
  logic             ctrl_reg, c_reg;
  logic [CW-1:0]    k_reg;

  logic [DIGIT-1:0] a_dig, b_dig;
  logic [DIGIT:0]   dsum;
  logic [WIDTH-1:0] res_next;
  logic             msb_cin;
  logic             last_dig;

  assign busy     = (state_reg == RUN);
  assign done     = (state_reg == DONE);
  assign last_dig = (k_reg == CW'(NDIG - 1));

  // Digit adder for slice k; also rebuilds the full result with this slice inserted.
  always_comb begin
    a_dig    = a_reg[int'(k_reg) * DIGIT +: DIGIT];
    b_dig    = b_reg[int'(k_reg) * DIGIT +: DIGIT] ^ {DIGIT{ctrl_reg}};
    dsum     = {1'b0, a_dig} + {1'b0, b_dig} + (DIGIT + 1)'(c_reg);
    res_next = res_reg;
    res_next[int'(k_reg) * DIGIT +: DIGIT] = dsum[DIGIT-1:0];
    // Carry into the top bit of the slice, recovered from the sum bit.
    msb_cin  = dsum[DIGIT-1] ^ a_dig[DIGIT-1] ^ b_dig[DIGIT-1];
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic; DONE always returns to IDLE so a held start costs one IDLE cycle.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_dig) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand latch, digit iteration and result/flag publication.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      ctrl_reg  <= 1'b0;
      c_reg     <= 1'b0;
      k_reg     <= '0;
      res_reg   <= '0;
      out       <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            a_reg    <= in1;
            b_reg    <= in2;
            ctrl_reg <= control;
            c_reg    <= carry_in;
            k_reg    <= '0;
          end
        end
        RUN: begin
          res_reg <= res_next;
          c_reg   <= dsum[DIGIT];
          k_reg   <= k_reg + CW'(1);
          if (last_dig) begin
            k_reg     <= '0;
            out       <= res_next;
            carry_out <= dsum[DIGIT];
            overflow  <= msb_cin ^ dsum[DIGIT];
            zero      <= (res_next == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
